// File: rtl/lift_pkg.sv
// Shared types and helpers for the lift dispatch scheduler.
package lift_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned CALC_W = 16;
  localparam logic [CALC_W-1:0] COST_MAX = '1;

  function automatic logic [CALC_W-1:0] abs_diff(input logic [CALC_W-1:0] a,
                                                 input logic [CALC_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/lift_cost_calc.sv
// Combinational eligibility and direction-aware travel cost for one lift against a hall call.
module lift_cost_calc
  import lift_pkg::*;
#(
  parameter int unsigned NUM_FLOORS = 8,
  parameter int unsigned CAPACITY   = 8,
  parameter int unsigned FLOOR_W    = $clog2(NUM_FLOORS),
  parameter int unsigned LOAD_W     = $clog2(CAPACITY + 1),
  parameter int unsigned COST_W     = FLOOR_W + 2
) (
  input  logic [FLOOR_W-1:0] curr,
  input  logic [FLOOR_W-1:0] dest,
  input  logic [LOAD_W-1:0]  load,
  input  logic [FLOOR_W-1:0] req_floor,
  input  logic               req_dir,
  output logic               eligible_c,
  output logic [COST_W-1:0]  cost_c
);

  localparam int unsigned FLOOR_CMP_W = FLOOR_W + 1;
  localparam logic [FLOOR_W:0] FLOOR_LIM = FLOOR_CMP_W'(NUM_FLOORS);
  localparam logic [LOAD_W-1:0] LOAD_LIM = LOAD_W'(CAPACITY);

  logic [CALC_W-1:0] d_req_curr;
  logic [CALC_W-1:0] d_curr_dest;
  logic [CALC_W-1:0] d_dest_req;
  logic              moving_up;
  logic              moving_down;

  always_comb begin
    d_req_curr  = abs_diff(CALC_W'(req_floor), CALC_W'(curr));
    d_curr_dest = abs_diff(CALC_W'(curr), CALC_W'(dest));
    d_dest_req  = abs_diff(CALC_W'(dest), CALC_W'(req_floor));
    moving_up   = dest > curr;
    moving_down = dest < curr;

    eligible_c = (load < LOAD_LIM) && ({1'b0, curr} < FLOOR_LIM) && ({1'b0, dest} < FLOOR_LIM);

    // Lifts that will pass the caller on their current run go direct; others finish their run first.
    if (!moving_up && !moving_down) begin
      cost_c = COST_W'(d_req_curr);
    end else if (moving_up && req_dir && (curr <= req_floor)) begin
      cost_c = COST_W'(d_req_curr);
    end else if (moving_down && !req_dir && (curr >= req_floor)) begin
      cost_c = COST_W'(d_req_curr);
    end else begin
      cost_c = COST_W'(d_curr_dest + d_dest_req);
    end
  end

endmodule

// File: rtl/lift_dispatch_scheduler.sv
// N-lift hall-call dispatcher: accepts one call, scans every lift one per cycle,
// and pulses the cheapest eligible lift.
module lift_dispatch_scheduler
  import lift_pkg::*;
#(
  parameter int unsigned NUM_LIFTS  = 4,
  parameter int unsigned NUM_FLOORS = 8,
  parameter int unsigned CAPACITY   = 8,
  parameter int unsigned FLOOR_W    = $clog2(NUM_FLOORS),
  parameter int unsigned LOAD_W     = $clog2(CAPACITY + 1),
  parameter int unsigned LIFT_W     = $clog2(NUM_LIFTS)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [FLOOR_W-1:0]             req_floor,
  input  logic                           req_dir,
  input  logic [NUM_LIFTS*FLOOR_W-1:0]   lift_curr_floor,
  input  logic [NUM_LIFTS*FLOOR_W-1:0]   lift_dest_floor,
  input  logic [NUM_LIFTS*LOAD_W-1:0]    lift_load,
  output logic                           asg_valid,
  output logic                           asg_none,
  output logic [LIFT_W-1:0]              asg_lift,
  output logic [FLOOR_W-1:0]             asg_floor,
  output logic [FLOOR_W+1:0]             asg_cost
);

  localparam int unsigned COST_W      = FLOOR_W + 2;
  localparam int unsigned FLOOR_CMP_W = FLOOR_W + 1;
  localparam logic [FLOOR_W:0]    FLOOR_LIM = FLOOR_CMP_W'(NUM_FLOORS);
  localparam logic [LIFT_W-1:0]   LAST_IDX  = LIFT_W'(NUM_LIFTS - 1);
  localparam logic [COST_W-1:0]   NONE_COST = COST_W'(COST_MAX);

  state_e state, state_d;

  logic [LIFT_W-1:0]  idx;
  logic [FLOOR_W-1:0] req_floor_q;
  logic               req_dir_q;
  logic [COST_W-1:0]  best_cost;
  logic [LIFT_W-1:0]  best_lift;
  logic               best_found;

  logic [FLOOR_W-1:0] curr_a [NUM_LIFTS];
  logic [FLOOR_W-1:0] dest_a [NUM_LIFTS];
  logic [LOAD_W-1:0]  load_a [NUM_LIFTS];
  logic [FLOOR_W-1:0] sel_curr_c;
  logic [FLOOR_W-1:0] sel_dest_c;
  logic [LOAD_W-1:0]  sel_load_c;

  logic               cand_eligible_c;
  logic [COST_W-1:0]  cand_cost_c;
  logic               req_floor_ok_c;
  logic               last_c;
  logic               take_c;
  logic               fin_found_c;
  logic [COST_W-1:0]  fin_cost_c;
  logic [LIFT_W-1:0]  fin_lift_c;

  logic               req_ready_d;
  logic               asg_valid_d;
  logic               asg_none_d;
  logic [LIFT_W-1:0]  asg_lift_d;
  logic [FLOOR_W-1:0] asg_floor_d;
  logic [COST_W-1:0]  asg_cost_d;

  // Unpack per-lift buses and select the lift under evaluation this cycle.
  always_comb begin
    for (int i = 0; i < NUM_LIFTS; i++) begin
      curr_a[i] = lift_curr_floor[i*FLOOR_W +: FLOOR_W];
      dest_a[i] = lift_dest_floor[i*FLOOR_W +: FLOOR_W];
      load_a[i] = lift_load[i*LOAD_W +: LOAD_W];
    end
    sel_curr_c = curr_a[idx];
    sel_dest_c = dest_a[idx];
    sel_load_c = load_a[idx];
  end

  lift_cost_calc #(
    .NUM_FLOORS (NUM_FLOORS),
    .CAPACITY   (CAPACITY),
    .FLOOR_W    (FLOOR_W),
    .LOAD_W     (LOAD_W),
    .COST_W     (COST_W)
  ) u_cost (
    .curr       (sel_curr_c),
    .dest       (sel_dest_c),
    .load       (sel_load_c),
    .req_floor  (req_floor_q),
    .req_dir    (req_dir_q),
    .eligible_c (cand_eligible_c),
    .cost_c     (cand_cost_c)
  );

  // Running minimum including the lift evaluated this cycle; strict less-than keeps the lower index on ties.
  always_comb begin
    req_floor_ok_c = {1'b0, req_floor} < FLOOR_LIM;
    last_c         = idx == LAST_IDX;
    take_c         = (state == SCAN) && cand_eligible_c && (!best_found || (cand_cost_c < best_cost));
    fin_found_c    = (state == SCAN) && (best_found || take_c);
    fin_cost_c     = take_c ? cand_cost_c : best_cost;
    fin_lift_c     = take_c ? idx : best_lift;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (req_valid) state_d = req_floor_ok_c ? SCAN : DONE;
      SCAN:    if (last_c) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Result is captured on the edge entering DONE and held until the next result.
  always_comb begin
    req_ready_d = state_d == IDLE;
    asg_valid_d = state_d == DONE;
    asg_none_d  = asg_none;
    asg_lift_d  = asg_lift;
    asg_floor_d = asg_floor;
    asg_cost_d  = asg_cost;
    if ((state != DONE) && (state_d == DONE)) begin
      asg_none_d  = !fin_found_c;
      asg_lift_d  = fin_found_c ? fin_lift_c : '0;
      asg_cost_d  = fin_found_c ? fin_cost_c : NONE_COST;
      asg_floor_d = (state == IDLE) ? req_floor : req_floor_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_ready <= 1'b1;
      asg_valid <= 1'b0;
      asg_none  <= 1'b0;
      asg_lift  <= '0;
      asg_floor <= '0;
      asg_cost  <= '0;
    end else begin
      req_ready <= req_ready_d;
      asg_valid <= asg_valid_d;
      asg_none  <= asg_none_d;
      asg_lift  <= asg_lift_d;
      asg_floor <= asg_floor_d;
      asg_cost  <= asg_cost_d;
    end
  end

  // Scan datapath: latch the call on accept, then fold in one lift per cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx         <= '0;
      req_floor_q <= '0;
      req_dir_q   <= 1'b0;
      best_cost   <= NONE_COST;
      best_lift   <= '0;
      best_found  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            req_floor_q <= req_floor;
            req_dir_q   <= req_dir;
            idx         <= '0;
            best_cost   <= NONE_COST;
            best_lift   <= '0;
            best_found  <= 1'b0;
          end
        end
        SCAN: begin
          if (take_c) begin
            best_cost  <= cand_cost_c;
            best_lift  <= idx;
            best_found <= 1'b1;
          end
          idx <= idx + LIFT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
